uart_tx_queue: RTL and testbench

Buffered 16-bit UART transmitter: accepts words on a valid/ready input, queues them in a small FIFO and serialises them back-to-back as frames of start bit, 16 data bits LSB first and stop bit. It is the transmit end that feeds `uart_rx` (16-bit word format). Upstream producers (RLE encoder output, host command path) can push bursts without polling a per-word done.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_queue.sv | 148 ++++++++++++++
 tb/tb_uart_tx_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: word width, idle line level and frame-state encodings.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 16;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Read data is the head entry, valid
// whenever the FIFO is non-empty. Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage array; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered 16-bit UART transmitter: FIFO-fed, back-to-back frames of
// start bit, 16 data bits LSB first, optional even parity, stop bit.
// Optional feature: define UART_TXQ_PARITY_EN to insert an even-parity bit.
// Line outputs are registered from the FSM state, so the line lags the state by one cycle.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 435,
    parameter int DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      valid,
    output logic                      ready,
    output logic                      dout,
    output logic                      active,
    output logic                      done,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam int            BW       = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(UART_DATA_BITS - 1);

    uart_state_e               state_q;
    logic [TW-1:0]             timer_q;
    logic [BW-1:0]             bit_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      dout_q;
    logic                      active_q;
    logic                      done_q;

    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      bit_end;
    logic                      pop;

`ifdef UART_TXQ_PARITY_EN
    logic parity_q;
`endif

    assign bit_end = (timer_q == BIT_LAST);
    // Pop when idle, or on the final stop-bit cycle so the next frame follows with no gap.
    assign pop     = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
    assign ready   = !fifo_full;
    assign dout    = dout_q;
    assign active  = active_q;
    assign done    = done_q;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (valid),
        .pop_i   (pop),
        .wdata_i (din),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // Frame FSM with bit timer, bit index and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            dout_q   <= UART_IDLE_LEVEL;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            active_q <= (state_q != ST_IDLE);
            done_q   <= (state_q == ST_STOP) && bit_end;
            timer_q  <= bit_end ? '0 : timer_q + TW'(1);
            case (state_q)
                ST_START: dout_q <= 1'b0;
                ST_DATA:  dout_q <= shift_q[0];
`ifdef UART_TXQ_PARITY_EN
                ST_PARITY: dout_q <= parity_q;
`endif
                default:  dout_q <= UART_IDLE_LEVEL;
            endcase
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (pop) begin
                        state_q <= ST_START;
                        bit_q   <= '0;
                    end
                end
                ST_START: begin
                    if (bit_end) state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_q <= bit_q + BW'(1);
                        if (bit_q == IDX_LAST) begin
`ifdef UART_TXQ_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TXQ_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) state_q <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state_q <= ST_START;
                            bit_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Shift register loads the popped word and shifts right at each data-bit boundary.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q <= fifo_rdata;
        end else if ((state_q == ST_DATA) && bit_end) begin
            shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
        end
    end

`ifdef UART_TXQ_PARITY_EN
    // Even parity of the popped word, captured alongside it.
    always_ff @(posedge clk) begin
        if (pop) parity_q <= ^fifo_rdata;
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a line-level receiver model decodes
// frames from dout and is compared with the queue of words the bench pushed.
module tb_uart_tx_queue;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TXQ_PARITY_EN
    localparam int FRAME_BITS = 19;
`else
    localparam int FRAME_BITS = 18;
`endif
    localparam int FRAME_LEN = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        valid;
    logic        ready;
    logic        dout;
    logic        active;
    logic        done;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_tx_queue #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .valid  (valid),
        .ready  (ready),
        .dout   (dout),
        .active (active),
        .done   (done),
        .count  (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected words in transmit order
    logic [15:0] exp_q [$];

    // Receiver model results, one entry per completed frame
    logic [15:0] rx_word  [$];
    bit          rx_start [$];
    bit          rx_stop  [$];
    bit          rx_par   [$];
    int          rx_done  [$];
    bit          rx_act   [$];
    int          rx_cyc   [$];
    int          done_total = 0;

    bit                    mon_busy = 0;
    int                    mon_t;
    int                    mon_start;
    int                    mon_done_t;
    bit                    mon_act_bad;
    logic [FRAME_BITS-1:0] mon_bits;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 0;
        end else begin
            if (done === 1'b1) done_total++;
            if (!mon_busy && dout === 1'b0) begin
                mon_busy    = 1;
                mon_t       = 0;
                mon_start   = cyc;
                mon_done_t  = -1;
                mon_act_bad = 0;
                mon_bits    = '0;
            end
            if (mon_busy) begin
                if (mon_t % CPB == CPB / 2) mon_bits[mon_t / CPB] = dout;
                if (done === 1'b1) mon_done_t = (mon_done_t == -1) ? mon_t : -2;
                if (active !== 1'b1) mon_act_bad = 1;
                if (mon_t == FRAME_LEN - 1) begin
                    rx_word.push_back(mon_bits[16:1]);
                    rx_start.push_back(mon_bits[0]);
                    rx_stop.push_back(mon_bits[FRAME_BITS-1]);
                    rx_par.push_back(mon_bits[FRAME_BITS-2]);
                    rx_done.push_back(mon_done_t);
                    rx_act.push_back(mon_act_bad);
                    rx_cyc.push_back(mon_start);
                    mon_busy = 0;
                end else begin
                    mon_t++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns the cycle number of the accept edge.
    task automatic push(input logic [15:0] w, output int acc);
        int b = 0;
        din   = w;
        valid = 1'b1;
        while (!ready && b < 2000) begin
            @(posedge clk); #1;
            b++;
        end
        chk("push_ready_timeout", 32'(b < 2000), 32'd1);
        @(posedge clk); #1;
        acc   = cyc;
        valid = 1'b0;
        din   = 16'($urandom);
        exp_q.push_back(w);
    endtask

    task automatic wait_frames(input int n);
        int b = 0;
        while (rx_word.size() < n && b < 20000) begin
            @(posedge clk); #1;
            b++;
        end
        chk("frame_timeout", 32'(rx_word.size() >= n), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        logic [15:0] w;
        logic [15:0] e;
        while (rx_word.size() > 0) begin
            w = rx_word.pop_front();
            chk("expected_word_available", 32'(exp_q.size() > 0), 32'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk("rx_word", {16'd0, w}, {16'd0, e});
            chk("start_bit", 32'(rx_start.pop_front()), 32'd0);
            chk("stop_bit", 32'(rx_stop.pop_front()), 32'd1);
            chk("done_offset", 32'(rx_done.pop_front()), 32'(FRAME_LEN - 1));
            chk("active_gap_in_frame", 32'(rx_act.pop_front()), 32'd0);
`ifdef UART_TXQ_PARITY_EN
            chk("parity_bit", 32'(rx_par.pop_front()), 32'(^e));
`else
            void'(rx_par.pop_front());
`endif
            void'(rx_cyc.pop_front());
        end
    endtask

    initial begin
        int acc;
        int a [6];
        int s;
        int d0;
        logic [15:0] w;

        rst_n = 1'b0;
        valid = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", 32'(dout), 32'd1);
        chk("reset_active", 32'(active), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word: latency, frame content, done timing
        push(16'h00AB, acc);
        chk("count_after_first_push", 32'(count), 32'd1);
        @(posedge clk); #1;
        chk("count_after_pop", 32'(count), 32'd0);
        chk("dout_before_start", 32'(dout), 32'd1);
        wait_frames(1);
        chk("start_latency", 32'(rx_cyc[0] - acc), 32'd2);
        chk("active_falls_after_done", 32'(active), 32'd0);
        drain();
        chk("single_done_count", 32'(done_total), 32'd1);

        // Burst past full: back-to-back frames
        d0 = done_total;
        for (int i = 0; i < 6; i++) begin
            push(16'($urandom), a[i]);
            if (i == 4) begin
                chk("burst_count_full", 32'(count), 32'd4);
                chk("burst_ready_low", 32'(ready), 32'd0);
            end
        end
        chk("burst_consecutive_accepts", 32'(a[4] - a[0]), 32'd4);
        chk("burst_sixth_waits", 32'(a[5] > a[4] + FRAME_LEN - 4), 32'd1);
        wait_frames(6);
        for (int k = 1; k < 6; k++) chk("back_to_back", 32'(rx_cyc[k] - rx_cyc[k-1]), 32'(FRAME_LEN));
        chk("burst_done_count", 32'(done_total - d0), 32'd6);
        drain();
        chk("active_low_after_burst", 32'(active), 32'd0);

        // Simultaneous push and pop at count 2
        push(16'h1111, acc);
        s = acc + 2;
        push(16'h2222, a[0]);
        push(16'h3333, a[1]);
        chk("count_two_before_pop", 32'(count), 32'd2);
        wait_cyc(s + FRAME_LEN - 2);
        chk("count_two_at_pop_cycle", 32'(count), 32'd2);
        push(16'h4444, acc);
        chk("push_on_pop_edge", 32'(acc - s), 32'(FRAME_LEN - 1));
        chk("count_unchanged_push_pop", 32'(count), 32'd2);
        wait_frames(4);
        drain();

        // Reset during data bit 7 with two words queued
        push(16'hA5A5, acc);
        s = acc + 2;
        push(16'h5A5A, a[0]);
        push(16'hC3C3, a[1]);
        wait_cyc(s + 8 * CPB + 1);
        d0 = done_total;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_dout", 32'(dout), 32'd1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_active", 32'(active), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        repeat (FRAME_LEN) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_total - d0), 32'd0);
        chk("midrst_no_frame", 32'(rx_word.size()), 32'd0);
        push(16'hBEEF, acc);
        wait_frames(1);
        chk("post_reset_latency", 32'(rx_cyc[0] - acc), 32'd2);
        drain();

        // Loopback-style pair and parity patterns
        push(16'h3F3F, acc);
        push(16'hFFFF, acc);
        push(16'h0007, acc);
        push(16'h0003, acc);
        wait_frames(4);
`ifdef UART_TXQ_PARITY_EN
        chk("parity_0007", 32'(rx_par[2]), 32'd1);
        chk("parity_0003", 32'(rx_par[3]), 32'd0);
`endif
        drain();

        // Randomized words with random gaps
        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom);
            push(w, acc);
            repeat ($urandom_range(0, 90)) @(posedge clk);
            #1;
        end
        wait_frames(exp_q.size());
        drain();
        chk("all_words_sent", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle_dout", 32'(dout), 32'd1);
        chk("final_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
